bram_port_arbiter: RTL and testbench
====================================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 1, meaning the BRAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, meaning the data width; it SHALL equal WE_WIDTH*8.
REQ-003 The block SHALL have parameter WE_WIDTH, default 1, meaning the number of byte enables.
REQ-004 The block SHALL have parameter PIPELINED, default 0, meaning BRAM read latency LAT = 1 when 0 and LAT = 2 when 1.
REQ-005 Port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 Ports reqN_valid (in, 1), reqN_ready (out, 1), reqN_we (in, WE_WIDTH), reqN_addr (in, ADDR_WIDTH) and reqN_wdata (in, DATA_WIDTH), for N = 0 and 1: the request channel of requester N.
REQ-008 Ports respN_valid (out, 1), respN_ready (in, 1) and respN_rdata (out, DATA_WIDTH), for N = 0 and 1: the response channel of requester N.
REQ-009 Ports bram_en (out, 1), bram_we (out, WE_WIDTH), bram_addr (out, ADDR_WIDTH), bram_din (out, DATA_WIDTH) and bram_dout (in, DATA_WIDTH): one write-first byte-enable BRAM port.

Function
REQ-010 A request SHALL be accepted in a cycle where reqN_valid and reqN_ready are both high.
- At most one request is accepted per cycle.
REQ-011 In the accept cycle, the outputs SHALL be:
- bram_en = 1;
- bram_we, bram_addr and bram_din = the winner's fields, combinationally.
- In all other cycles bram_en = 0 and bram_we = 0.
REQ-012 Requester N SHALL be eligible only when resp_count_N + inflight_N < RESP_DEPTH (4).
- resp_count_N is the occupancy of N's response buffer.
- inflight_N is the number of N's tags in the latency pipe.
REQ-013 Arbitration SHALL be round-robin with a 1-bit last-grant pointer.
- If both requesters are valid and eligible, the requester not last granted wins.
- If only one is valid and eligible, it wins.
- The pointer updates only on an accept.
REQ-014 reqN_ready SHALL be high exactly when requester N is eligible and wins arbitration this cycle. It SHALL be independent of respN_ready.
REQ-015 Every accepted request, read or write, SHALL produce exactly one response.
- For a read (we = 0), rdata is the stored word.
- For a write, rdata is the write-first merged word returned on bram_dout.
REQ-016 A tag pipe of depth LAT SHALL carry {valid, requester id}.
- bram_dout SHALL be captured into the tagged requester's buffer exactly LAT cycles after the accept edge.
REQ-017 Each response buffer SHALL be a 4-entry FIFO.
- respN_valid = (count != 0); respN_rdata = the head entry.
- A pop occurs when respN_valid and respN_ready are both high.
- A simultaneous push and pop leaves count unchanged.
REQ-018 Responses SHALL be returned in accept order per requester.
- Earliest respN_valid is LAT+1 cycles after the accept edge; there is no bypass.
REQ-019 REQ-012 guarantees no buffer overflow, so a push into a full buffer SHALL be unreachable. The bench SHALL assert that it never occurs.
REQ-020 With respN_ready held high, one requester alone SHALL sustain one accept per cycle.

Reset
REQ-021 While RST is high, the following SHALL hold:
- outputs: bram_en = 0, bram_we = 0, reqN_ready = 0, respN_valid = 0;
- all tag valids cleared, both FIFO counts = 0, pointer = 1 (so requester 0 wins first).
REQ-022 A reset asserted mid-operation SHALL discard all in-flight tags and buffered responses.
- BRAM data returned after the reset is ignored.
- Operation resumes in the first cycle after RST falls.

Structure
REQ-023 A shared package SHALL hold:
- RESP_DEPTH = 4;
- the LAT derivation from PIPELINED;
- the requester-id type (1 bit);
- the tag record {valid, id}.
REQ-024 The response FIFO SHALL be one sub-module, bram_arb_resp_fifo, instantiated twice.
- Ports: CLK, RST, push, push_data, pop, head, count.

Verification
REQ-025 PIPELINED=0: req0 writes addr 3, we=1, wdata 0xA5; then req0 reads addr 3 -> two responses on resp0, both 0xA5, the read response valid 2 cycles after its accept.
REQ-026 PIPELINED=1: req0 and req1 both valid every cycle reading addrs 0 and 1 -> grants alternate 0,1,0,1 starting with requester 0; each response is valid 3 cycles after its accept.
REQ-027 resp1_ready held low; req1 issues 6 reads -> exactly 4 accepted, then req1_ready = 0 while req0 is still served; after resp1_ready goes high, the remaining 2 are accepted.
REQ-028 WE_WIDTH=4: word at addr 5 = 0x11223344; req1 writes we=4'b0010, wdata 0xFFFFFFFF -> write response 0x1122FF44; a subsequent read returns 0x1122FF44.
REQ-029 RST pulsed 1 cycle while 2 reads are in flight -> no respN_valid after reset, FIFO counts 0, and the first accept after reset goes to requester 0.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_port_arbiter_pkg                                              |
// | Shared constants, tag record and latency helper for the arbiter.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bram_port_arbiter_pkg;

   localparam int RESP_DEPTH = 4;
   localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
   localparam int PTR_W      = $clog2(RESP_DEPTH);
   localparam int INFL_W     = 2;

   typedef logic req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

   // Read latency of the attached BRAM: output register adds one cycle.
   function automatic int lat_of(input int pipelined);
      return (pipelined != 0) ? 2 : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arb_resp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_arb_resp_fifo                                                 |
// | Small per-requester response FIFO with head-of-queue output.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bram_arb_resp_fifo
   import bram_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [CNT_W-1:0]      count
);

   localparam logic [CNT_W-1:0] c_full = CNT_W'(RESP_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   assign w_do_push = push && (r_count != c_full);
   assign w_do_pop  = pop && (r_count != '0);

   always_ff @(posedge CLK) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_port_arbiter                                                  |
// | Round-robin sharing of one BRAM port between two requesters.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bram_port_arbiter
   import bram_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 8,
   parameter int WE_WIDTH   = 1,
   parameter int PIPELINED  = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [WE_WIDTH-1:0]   req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [WE_WIDTH-1:0]   req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  resp0_valid,
   input  logic                  resp0_ready,
   output logic [DATA_WIDTH-1:0] resp0_rdata,
   output logic                  resp1_valid,
   input  logic                  resp1_ready,
   output logic [DATA_WIDTH-1:0] resp1_rdata,
   output logic                  bram_en,
   output logic [WE_WIDTH-1:0]   bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout
);

   localparam int LAT   = lat_of(PIPELINED);
   localparam int OUT_W = CNT_W + 1;
   localparam logic [OUT_W-1:0] c_limit = OUT_W'(RESP_DEPTH);

   tag_t             r_tag_pipe [LAT];
   req_id_t          r_last_grant;

   tag_t             w_new_tag;
   tag_t             w_cap_tag;
   logic [CNT_W-1:0] w_count0, w_count1;
   logic [INFL_W-1:0] w_inflight0, w_inflight1;
   logic [OUT_W-1:0] w_outst0, w_outst1;
   logic             w_cand0, w_cand1;
   logic             w_grant0, w_grant1;
   logic             w_accept;
   req_id_t          w_winner;
   logic             w_push0, w_push1;
   logic             w_pop0, w_pop1;

   always_comb begin
      w_inflight0 = '0;
      w_inflight1 = '0;
      for (int i = 0; i < LAT; i++) begin
         if (r_tag_pipe[i].valid && (r_tag_pipe[i].id == 1'b0)) w_inflight0 = w_inflight0 + INFL_W'(1);
         if (r_tag_pipe[i].valid && (r_tag_pipe[i].id == 1'b1)) w_inflight1 = w_inflight1 + INFL_W'(1);
      end
   end

   // Buffered plus in-flight responses bound what a requester may still issue.
   assign w_outst0 = OUT_W'(w_count0) + OUT_W'(w_inflight0);
   assign w_outst1 = OUT_W'(w_count1) + OUT_W'(w_inflight1);
   assign w_cand0  = !RST && req0_valid && (w_outst0 < c_limit);
   assign w_cand1  = !RST && req1_valid && (w_outst1 < c_limit);

   assign w_grant0 = w_cand0 && (!w_cand1 || (r_last_grant == 1'b1));
   assign w_grant1 = w_cand1 && (!w_cand0 || (r_last_grant == 1'b0));
   assign w_accept = w_grant0 || w_grant1;
   assign w_winner = w_grant1;

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   assign bram_en   = w_accept;
   assign bram_we   = w_accept ? (w_winner ? req1_we : req0_we) : '0;
   assign bram_addr = w_winner ? req1_addr  : req0_addr;
   assign bram_din  = w_winner ? req1_wdata : req0_wdata;

   always_comb begin
      w_new_tag       = '0;
      w_new_tag.valid = w_accept;
      w_new_tag.id    = w_winner;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < LAT; i++) r_tag_pipe[i] <= '0;
         r_last_grant <= 1'b1;
      end else begin
         r_tag_pipe[0] <= w_new_tag;
         for (int i = 1; i < LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
         if (w_accept) r_last_grant <= w_winner;
      end
   end

   // The oldest tag lines up with the BRAM output for this cycle.
   assign w_cap_tag = r_tag_pipe[LAT-1];
   assign w_push0   = w_cap_tag.valid && (w_cap_tag.id == 1'b0);
   assign w_push1   = w_cap_tag.valid && (w_cap_tag.id == 1'b1);

   assign resp0_valid = !RST && (w_count0 != '0);
   assign resp1_valid = !RST && (w_count1 != '0);
   assign w_pop0      = resp0_valid && resp0_ready;
   assign w_pop1      = resp1_valid && resp1_ready;

   bram_arb_resp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_resp_fifo0 (
      .CLK       (CLK),
      .RST       (RST),
      .push      (w_push0),
      .push_data (bram_dout),
      .pop       (w_pop0),
      .head      (resp0_rdata),
      .count     (w_count0)
   );

   bram_arb_resp_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_resp_fifo1 (
      .CLK       (CLK),
      .RST       (RST),
      .push      (w_push1),
      .push_data (bram_dout),
      .pop       (w_pop1),
      .head      (resp1_rdata),
      .count     (w_count1)
   );

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bram_port_arbiter                                               |
// | Directed bench: 8-bit LAT=1 and 32-bit LAT=2 arbiters, shared bus. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        r0v, r1v;
   logic [3:0]  r0we, r1we;
   logic [3:0]  r0a, r1a;
   logic [31:0] r0d, r1d;
   logic        s0r, s1r;

   logic        a_r0rdy, a_r1rdy, a_s0v, a_s1v, a_en;
   logic [7:0]  a_s0d, a_s1d, a_din, a_dout;
   logic [0:0]  a_we;
   logic [3:0]  a_addr;
   logic [7:0]  a_mem [16];

   logic        b_r0rdy, b_r1rdy, b_s0v, b_s1v, b_en;
   logic [31:0] b_s0d, b_s1d, b_din, b_dout, b_stage, b_merged;
   logic [3:0]  b_we;
   logic [3:0]  b_addr;
   logic [31:0] b_mem [16];

   int checks   = 0;
   int failures = 0;
   int acc1     = 0;
   int acc1_base;

   bram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WE_WIDTH(1), .PIPELINED(0)) dut_a (
      .CLK(clk), .RST(rst),
      .req0_valid(r0v), .req0_ready(a_r0rdy), .req0_we(r0we[0:0]), .req0_addr(r0a), .req0_wdata(r0d[7:0]),
      .req1_valid(r1v), .req1_ready(a_r1rdy), .req1_we(r1we[0:0]), .req1_addr(r1a), .req1_wdata(r1d[7:0]),
      .resp0_valid(a_s0v), .resp0_ready(s0r), .resp0_rdata(a_s0d),
      .resp1_valid(a_s1v), .resp1_ready(s1r), .resp1_rdata(a_s1d),
      .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din), .bram_dout(a_dout)
   );

   bram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WE_WIDTH(4), .PIPELINED(1)) dut_b (
      .CLK(clk), .RST(rst),
      .req0_valid(r0v), .req0_ready(b_r0rdy), .req0_we(r0we), .req0_addr(r0a), .req0_wdata(r0d),
      .req1_valid(r1v), .req1_ready(b_r1rdy), .req1_we(r1we), .req1_addr(r1a), .req1_wdata(r1d),
      .resp0_valid(b_s0v), .resp0_ready(s0r), .resp0_rdata(b_s0d),
      .resp1_valid(b_s1v), .resp1_ready(s1r), .resp1_rdata(b_s1d),
      .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din), .bram_dout(b_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first BRAM models: one output stage for dut_a, two for dut_b.
   always @(posedge clk) begin
      if (a_en) begin
         if (a_we[0]) begin
            a_mem[a_addr] <= a_din;
            a_dout        <= a_din;
         end else begin
            a_dout <= a_mem[a_addr];
         end
      end
   end

   always @(posedge clk) begin
      if (b_en) begin
         b_merged = b_mem[b_addr];
         for (int i = 0; i < 4; i++)
            if (b_we[i]) b_merged[8*i +: 8] = b_din[8*i +: 8];
         b_mem[b_addr] <= b_merged;
         b_stage       <= b_merged;
      end
      b_dout <= b_stage;
   end

   always @(negedge clk) begin
      if (r1v && b_r1rdy) acc1 = acc1 + 1;
   end

   // A push into a full response buffer must never happen.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!((dut_b.u_resp_fifo0.push && dut_b.u_resp_fifo0.count == 3'd4) ||
                   (dut_b.u_resp_fifo1.push && dut_b.u_resp_fifo1.count == 3'd4) ||
                   (dut_a.u_resp_fifo0.push && dut_a.u_resp_fifo0.count == 3'd4) ||
                   (dut_a.u_resp_fifo1.push && dut_a.u_resp_fifo1.count == 3'd4)))
         else begin
            failures++;
            $error("FAIL fifo_overflow observed=push_into_full expected=no_push_into_full");
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      // Reset with both requesters already valid (full-word writes).
      rst = 1'b1; s0r = 1'b1; s1r = 1'b1;
      r0v = 1'b1; r0we = 4'hF; r0a = 4'd0; r0d = 32'h0000_1000;
      r1v = 1'b1; r1we = 4'hF; r1a = 4'd1; r1d = 32'h0000_2001;
      repeat (2) @(posedge clk);
      smp();
      check("rst_r0rdy", b_r0rdy, 0);
      check("rst_r1rdy", b_r1rdy, 0);
      check("rst_en",    b_en, 0);
      check("rst_we",    b_we, 0);
      check("rst_s0v",   b_s0v, 0);
      check("rst_s1v",   b_s1v, 0);

      nxt(); rst = 1'b0;
      smp();
      check("first_r0rdy", b_r0rdy, 1);
      check("first_r1rdy", b_r1rdy, 0);
      check("first_en",    b_en, 1);
      check("first_din",   b_din, 32'h0000_1000);
      nxt(); r0v = 1'b0;
      smp();
      check("a2_r1rdy", b_r1rdy, 1);
      check("a2_addr",  b_addr, 1);
      nxt(); r1v = 1'b0;
      smp();
      check("a3_no_bypass_s0v", b_s0v, 0);
      check("a3_idle_we", b_we, 0);
      nxt(); smp();
      check("a4_s0v", b_s0v, 1);
      check("a4_s0d", b_s0d, 32'h0000_1000);
      nxt(); smp();
      check("a5_s1v", b_s1v, 1);
      check("a5_s1d", b_s1d, 32'h0000_2001);
      check("a5_s0v", b_s0v, 0);

      // Both requesters reading every cycle: grants alternate starting with 0.
      nxt(); r0v = 1'b1; r0we = 4'h0; r0a = 4'd0; r1v = 1'b1; r1we = 4'h0; r1a = 4'd1;
      smp();
      check("rr0_r0rdy", b_r0rdy, 1);
      check("rr0_r1rdy", b_r1rdy, 0);
      nxt(); smp();
      check("rr1_r0rdy", b_r0rdy, 0);
      check("rr1_r1rdy", b_r1rdy, 1);
      nxt(); smp();
      check("rr2_r0rdy", b_r0rdy, 1);
      check("rr2_s0v",   b_s0v, 0);
      nxt(); smp();
      check("rr3_r1rdy", b_r1rdy, 1);
      check("rr3_s0v",   b_s0v, 1);
      check("rr3_s0d",   b_s0d, 32'h0000_1000);
      nxt(); r0v = 1'b0; r1v = 1'b0;
      smp();
      check("rr4_s1v", b_s1v, 1);
      check("rr4_s1d", b_s1d, 32'h0000_2001);
      check("rr4_s0v", b_s0v, 0);
      nxt(); smp();
      check("rr5_s0v", b_s0v, 1);
      nxt(); smp();
      check("rr6_s1v", b_s1v, 1);

      // Write then read of addr 3; dut_a has one cycle less latency.
      nxt(); r0v = 1'b1; r0we = 4'hF; r0a = 4'd3; r0d = 32'h0000_00A5;
      smp();
      check("wr_a_r0rdy", a_r0rdy, 1);
      nxt(); r0we = 4'h0;
      smp();
      check("rd_a_r0rdy", a_r0rdy, 1);
      check("wr_a_s0v_early", a_s0v, 0);
      nxt(); r0v = 1'b0;
      smp();
      check("wr_a_s0v", a_s0v, 1);
      check("wr_a_s0d", a_s0d, 8'hA5);
      check("wr_b_s0v_early", b_s0v, 0);
      nxt(); smp();
      check("rd_a_s0v", a_s0v, 1);
      check("rd_a_s0d", a_s0d, 8'hA5);
      check("wr_b_s0d", b_s0d, 32'h0000_00A5);
      nxt(); smp();
      check("rd_a_s0v_done", a_s0v, 0);
      check("rd_b_s0v", b_s0v, 1);
      check("rd_b_s0d", b_s0d, 32'h0000_00A5);

      // Backpressure on resp1: at most four outstanding reads for requester 1.
      acc1_base = acc1;
      nxt(); s1r = 1'b0; r1v = 1'b1; r1we = 4'h0; r1a = 4'd1;
      smp(); check("bp0_r1rdy", b_r1rdy, 1);
      nxt(); smp(); check("bp1_r1rdy", b_r1rdy, 1);
      nxt(); smp(); check("bp2_r1rdy", b_r1rdy, 1);
      nxt(); smp(); check("bp3_r1rdy", b_r1rdy, 1);
      nxt(); r0v = 1'b1; r0we = 4'h0; r0a = 4'd0;
      smp();
      check("bp4_r1rdy", b_r1rdy, 0);
      check("bp4_r0rdy", b_r0rdy, 1);
      nxt(); r0v = 1'b0;
      smp();
      check("bp5_r1rdy", b_r1rdy, 0);
      check("bp5_s1v", b_s1v, 1);
      check("bp5_s1d", b_s1d, 32'h0000_2001);
      nxt(); smp(); check("bp6_r1rdy", b_r1rdy, 0);
      nxt(); smp();
      check("bp7_s0d", b_s0d, 32'h0000_1000);
      #1; check("bp7_accepts", acc1 - acc1_base, 4);
      nxt(); s1r = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         if (acc1 - acc1_base >= 6) break;
      end
      nxt(); r1v = 1'b0;
      repeat (6) nxt();
      smp();
      check("bp_total_accepts", acc1 - acc1_base, 6);
      check("bp_drained_s1v", b_s1v, 0);

      // Byte-enable merge at addr 5.
      nxt(); r1v = 1'b1; r1we = 4'hF; r1a = 4'd5; r1d = 32'h1122_3344;
      smp(); check("be0_r1rdy", b_r1rdy, 1);
      nxt(); r1we = 4'b0010; r1d = 32'hFFFF_FFFF;
      smp();
      check("be1_we",  b_we, 4'b0010);
      check("be1_din", b_din, 32'hFFFF_FFFF);
      nxt(); r1we = 4'h0;
      smp(); check("be2_r1rdy", b_r1rdy, 1);
      nxt(); r1v = 1'b0;
      smp(); check("be_preload_resp", b_s1d, 32'h1122_3344);
      nxt(); smp();
      check("be_write_resp_v", b_s1v, 1);
      check("be_write_resp", b_s1d, 32'h1122_FF44);
      nxt(); smp();
      check("be_read_resp", b_s1d, 32'h1122_FF44);
      nxt(); smp();
      check("be_done_s1v", b_s1v, 0);

      // Reset pulse with two reads in flight.
      nxt(); r0v = 1'b1; r0we = 4'h0; r0a = 4'd0; r1v = 1'b1; r1we = 4'h0; r1a = 4'd1;
      smp(); check("mr0_r0rdy", b_r0rdy, 1);
      nxt(); smp(); check("mr1_r1rdy", b_r1rdy, 1);
      nxt(); rst = 1'b1;
      smp();
      check("mr_rst_r0rdy", b_r0rdy, 0);
      check("mr_rst_en", b_en, 0);
      nxt(); rst = 1'b0;
      smp();
      check("mr3_s0v", b_s0v, 0);
      check("mr3_s1v", b_s1v, 0);
      check("mr3_cnt0", dut_b.u_resp_fifo0.count, 0);
      check("mr3_cnt1", dut_b.u_resp_fifo1.count, 0);
      check("mr3_r0rdy", b_r0rdy, 1);
      check("mr3_r1rdy", b_r1rdy, 0);
      check("mr3_a_r0rdy", a_r0rdy, 1);
      nxt(); r0v = 1'b0;
      smp();
      check("mr4_r1rdy", b_r1rdy, 1);
      check("mr4_s0v", b_s0v, 0);
      check("mr4_s1v", b_s1v, 0);
      nxt(); r1v = 1'b0;
      smp();
      check("mr5_s0v", b_s0v, 0);
      check("mr5_s1v", b_s1v, 0);
      nxt(); smp();
      check("mr6_s0v", b_s0v, 1);
      check("mr6_s0d", b_s0d, 32'h0000_1000);
      nxt(); smp();
      check("mr7_s1v", b_s1v, 1);
      check("mr7_s1d", b_s1d, 32'h0000_2001);
      nxt(); nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
